// File: rtl/dd_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dd_capture_pkg
// Brief   : Shared constants, capture entry layout and FIFO state encoding
//           for the DRAM data bus capture block.
// Revision: 1.0 - initial release
// ============================================================================
package dd_capture_pkg;

  // Width of the DRAM data bus being captured.
  localparam int DD_WIDTH = 7;

  // Width of the occupancy counter (covers 0..16).
  localparam int COUNT_W = 5;

  // One captured sample: is_float marks a capture taken while the bus was undriven.
  typedef struct packed {
    logic                is_float;
    logic [DD_WIDTH-1:0] data;
  } dd_entry_t;

  // FIFO occupancy state, decoded from the entry count.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

  // Builds the entry stored for one capture; an undriven bus stores zero data.
  function automatic dd_entry_t make_entry(input logic driven,
                                           input logic [DD_WIDTH-1:0] bus);
    dd_entry_t e;
    e.is_float = ~driven;
    e.data     = driven ? bus : '0;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : dd_fifo
// Brief   : DEPTH-entry FIFO of capture entries with a registered head entry.
//           The head register is zero whenever the FIFO is empty so stale
//           storage contents never reach the outputs.
// Revision: 1.0 - initial release
// ============================================================================
module dd_fifo
  import dd_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               push_i,
  input  dd_entry_t          push_data_i,
  input  logic               pop_ready_i,
  output logic               valid_o,
  output dd_entry_t          head_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               drop_o
);

  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [COUNT_W-1:0] c_full  = COUNT_W'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_one   = c_ptr_w'(1);

  dd_entry_t          mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  dd_entry_t          head_q, head_d;
  fifo_state_t        state;
  logic               w_pop;
  logic               w_push_ok;
  logic [c_ptr_w-1:0] w_rd_next;

  // Decode occupancy state and the accepted push/pop for this cycle.
  always_comb begin
    state = FIFO_PARTIAL;
    if (count_q == '0) begin
      state = FIFO_EMPTY;
    end else if (count_q == c_full) begin
      state = FIFO_FULL;
    end
    w_pop     = (state != FIFO_EMPTY) && pop_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    w_push_ok = push_i && ((state != FIFO_FULL) || w_pop);
    w_rd_next = rd_ptr_q + c_one;
  end

  // Next-state for pointers, count and the registered head entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_d = wr_ptr_q + c_one;
      end
      if (w_pop) begin
        rd_ptr_d = w_rd_next;
      end
      case ({w_push_ok, w_pop})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (w_pop) begin
        // Last entry leaving: head becomes the incoming entry or clears.
        if (count_q == 5'd1) begin
          head_d = w_push_ok ? push_data_i : '0;
        end else begin
          head_d = mem_q[w_rd_next];
        end
      end else if (w_push_ok && (state == FIFO_EMPTY)) begin
        head_d = push_data_i;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_push_ok && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (state != FIFO_EMPTY);
  assign head_o  = head_q;
  assign count_o = count_q;
  assign drop_o  = push_i && !w_push_ok;

endmodule
`default_nettype wire

// File: rtl/dd_capture.sv
`default_nettype none
// ============================================================================
// Module  : dd_capture
// Brief   : Captures the DRAM data bus on each rising edge of SAMPLE into a
//           FIFO, tagging captures taken while the bus was undriven, with
//           sticky overflow and float-error flags.
// Revision: 1.0 - initial release
// ============================================================================
module dd_capture
  import dd_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               MasterClock,
  input  logic               nReset,
  input  logic               inDD_0,
  input  logic               inDD_1,
  input  logic               inDD_2,
  input  logic               inDD_3,
  input  logic               inDD_4,
  input  logic               inDD_5,
  input  logic               inDD_6,
  input  logic               enDD,
  input  logic               SAMPLE,
  input  logic               CLR,
  output logic               RD_VALID,
  input  logic               RD_READY,
  output logic [DD_WIDTH-1:0] RD_DATA,
  output logic               RD_FLOAT,
  output logic [COUNT_W-1:0] COUNT,
  output logic               OVERFLOW,
  output logic               FLOATERR
);

  logic                sample_q, sample_d;
  logic                armed_q, armed_d;
  logic                overflow_q, overflow_d;
  logic                floaterr_q, floaterr_d;
  logic [DD_WIDTH-1:0] w_bus;
  logic                w_edge;
  logic                w_push;
  logic                w_drop;
  dd_entry_t           w_entry;
  dd_entry_t           w_head;

  assign w_bus = {inDD_6, inDD_5, inDD_4, inDD_3, inDD_2, inDD_1, inDD_0};

  // Edge detect, entry formation and sticky-flag next state; CLR wins over all.
  always_comb begin
    sample_d   = SAMPLE;
    // armed_q stays low for the first edge after reset so a SAMPLE already
    // high at release is not taken as a new request.
    armed_d    = 1'b1;
    w_edge     = SAMPLE && !sample_q && armed_q;
    w_push     = w_edge && !CLR;
    w_entry    = make_entry(enDD, w_bus);
    overflow_d = overflow_q;
    floaterr_d = floaterr_q;
    if (CLR) begin
      overflow_d = 1'b0;
      floaterr_d = 1'b0;
    end else begin
      if (w_drop) begin
        overflow_d = 1'b1;
      end
      if (w_edge && !enDD) begin
        floaterr_d = 1'b1;
      end
    end
  end

  // Edge-detect and flag registers.
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      sample_q   <= 1'b0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      floaterr_q <= 1'b0;
    end else begin
      sample_q   <= sample_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      floaterr_q <= floaterr_d;
    end
  end

  dd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (MasterClock),
    .rst_ni     (nReset),
    .clr_i      (CLR),
    .push_i     (w_push),
    .push_data_i(w_entry),
    .pop_ready_i(RD_READY),
    .valid_o    (RD_VALID),
    .head_o     (w_head),
    .count_o    (COUNT),
    .drop_o     (w_drop)
  );

  assign RD_DATA  = w_head.data;
  assign RD_FLOAT = w_head.is_float;
  assign OVERFLOW = overflow_q;
  assign FLOATERR = floaterr_q;

endmodule
`default_nettype wire

// File: tb/tb_dd_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_dd_capture
// Brief   : Directed, table-driven self-checking bench for dd_capture.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dd_capture;

  logic       clk;
  logic       rst_n;
  logic [6:0] bus;
  logic       en;
  logic       sample;
  logic       clr;
  logic       ready;
  logic       rd_valid;
  logic [6:0] rd_data;
  logic       rd_float;
  logic [4:0] count;
  logic       ovf;
  logic       ferr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       s;
    logic       e;
    logic [6:0] b;
    logic       r;
    logic       c;
    logic       xv;
    logic [6:0] xd;
    logic       xf;
    logic [4:0] xc;
    logic       xo;
    logic       xe;
  } vec_t;

  vec_t vq[$];

  dd_capture #(.DEPTH(4)) dut (
    .MasterClock(clk),
    .nReset     (rst_n),
    .inDD_0     (bus[0]),
    .inDD_1     (bus[1]),
    .inDD_2     (bus[2]),
    .inDD_3     (bus[3]),
    .inDD_4     (bus[4]),
    .inDD_5     (bus[5]),
    .inDD_6     (bus[6]),
    .enDD       (en),
    .SAMPLE     (sample),
    .CLR        (clr),
    .RD_VALID   (rd_valid),
    .RD_READY   (ready),
    .RD_DATA    (rd_data),
    .RD_FLOAT   (rd_float),
    .COUNT      (count),
    .OVERFLOW   (ovf),
    .FLOATERR   (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [6:0] d,
                         input logic f, input logic [4:0] c, input logic o, input logic e);
    chk({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, v});
    chk({tag, ".data"},  {25'd0, rd_data},  {25'd0, d});
    chk({tag, ".float"}, {31'd0, rd_float}, {31'd0, f});
    chk({tag, ".count"}, {27'd0, count},    {27'd0, c});
    chk({tag, ".ovf"},   {31'd0, ovf},      {31'd0, o});
    chk({tag, ".ferr"},  {31'd0, ferr},     {31'd0, e});
  endtask

  // Advance past the next rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic e, input logic [6:0] b, input logic r,
                     input logic c, input logic xv, input logic [6:0] xd, input logic xf,
                     input logic [4:0] xc, input logic xo, input logic xe);
    vec_t v;
    v.s = s; v.e = e; v.b = b; v.r = r; v.c = c;
    v.xv = xv; v.xd = xd; v.xf = xf; v.xc = xc; v.xo = xo; v.xe = xe;
    vq.push_back(v);
  endtask

  task automatic capture(input logic [6:0] b);
    bus = b; en = 1'b1; sample = 1'b1;
    step();
    sample = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; bus = '0; en = 1'b0; sample = 1'b0; clr = 1'b0; ready = 1'b0;

    //      s  e  bus    r  c   v  data   f  cnt   o  e
    add(0, 1, 7'h00, 0, 0,  0, 7'h00, 0, 5'd0, 0, 0); // idle after arm
    add(1, 1, 7'h55, 0, 0,  1, 7'h55, 0, 5'd1, 0, 0); // driven capture
    add(0, 1, 7'h00, 1, 0,  0, 7'h00, 0, 5'd0, 0, 0); // pop to empty
    add(1, 0, 7'h7F, 0, 0,  1, 7'h00, 1, 5'd1, 0, 1); // undriven capture
    add(0, 0, 7'h00, 1, 0,  0, 7'h00, 0, 5'd0, 0, 1); // pop, flag sticky
    add(0, 0, 7'h00, 0, 1,  0, 7'h00, 0, 5'd0, 0, 0); // CLR clears flag
    add(1, 1, 7'h01, 0, 0,  1, 7'h01, 0, 5'd1, 0, 0); // fill 1..5, no pops
    add(0, 1, 7'h00, 0, 0,  1, 7'h01, 0, 5'd1, 0, 0); // head held stable
    add(1, 1, 7'h02, 0, 0,  1, 7'h01, 0, 5'd2, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h01, 0, 5'd2, 0, 0);
    add(1, 1, 7'h03, 0, 0,  1, 7'h01, 0, 5'd3, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h01, 0, 5'd3, 0, 0);
    add(1, 1, 7'h04, 0, 0,  1, 7'h01, 0, 5'd4, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h01, 0, 5'd4, 0, 0);
    add(1, 1, 7'h05, 0, 0,  1, 7'h01, 0, 5'd4, 1, 0); // dropped: overflow
    add(0, 1, 7'h00, 1, 0,  1, 7'h02, 0, 5'd3, 1, 0); // drain in order
    add(0, 1, 7'h00, 1, 0,  1, 7'h03, 0, 5'd2, 1, 0);
    add(0, 1, 7'h00, 1, 0,  1, 7'h04, 0, 5'd1, 1, 0);
    add(0, 1, 7'h00, 1, 0,  0, 7'h00, 0, 5'd0, 1, 0);
    add(0, 1, 7'h00, 0, 1,  0, 7'h00, 0, 5'd0, 0, 0); // CLR clears overflow
    add(1, 1, 7'h0A, 0, 0,  1, 7'h0A, 0, 5'd1, 0, 0); // fill 0A..0D
    add(0, 1, 7'h00, 0, 0,  1, 7'h0A, 0, 5'd1, 0, 0);
    add(1, 1, 7'h0B, 0, 0,  1, 7'h0A, 0, 5'd2, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h0A, 0, 5'd2, 0, 0);
    add(1, 1, 7'h0C, 0, 0,  1, 7'h0A, 0, 5'd3, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h0A, 0, 5'd3, 0, 0);
    add(1, 1, 7'h0D, 0, 0,  1, 7'h0A, 0, 5'd4, 0, 0);
    add(0, 1, 7'h00, 0, 0,  1, 7'h0A, 0, 5'd4, 0, 0);
    add(1, 1, 7'h0E, 1, 0,  1, 7'h0B, 0, 5'd4, 0, 0); // full + pop: accepted
    add(0, 1, 7'h00, 1, 0,  1, 7'h0C, 0, 5'd3, 0, 0); // wrap order kept
    add(0, 1, 7'h00, 1, 0,  1, 7'h0D, 0, 5'd2, 0, 0);
    add(0, 1, 7'h00, 1, 0,  1, 7'h0E, 0, 5'd1, 0, 0);
    add(0, 1, 7'h00, 1, 0,  0, 7'h00, 0, 5'd0, 0, 0);
    add(1, 0, 7'h11, 0, 0,  1, 7'h00, 1, 5'd1, 0, 1); // set flag, then CLR+capture
    add(0, 1, 7'h00, 0, 0,  1, 7'h00, 1, 5'd1, 0, 1);
    add(1, 1, 7'h22, 1, 1,  0, 7'h00, 0, 5'd0, 0, 0); // CLR beats capture and pop
    add(0, 1, 7'h00, 0, 0,  0, 7'h00, 0, 5'd0, 0, 0); // nothing appears later

    // Reset state while nReset is held low.
    #12;
    chk_all("reset", 0, 7'h00, 0, 5'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); // first edge after release arms edge detection

    for (int i = 0; i < vq.size(); i++) begin
      sample = vq[i].s; en = vq[i].e; bus = vq[i].b; ready = vq[i].r; clr = vq[i].c;
      step();
      chk_all($sformatf("vec%0d", i), vq[i].xv, vq[i].xd, vq[i].xf, vq[i].xc, vq[i].xo, vq[i].xe);
    end
    sample = 1'b0; ready = 1'b0; clr = 1'b0; en = 1'b1;
    step();

    // SAMPLE held high for 10 cycles gives one entry.
    bus = 7'h33; sample = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_all("hold", 1, 7'h33, 0, 5'd1, 0, 0);
    sample = 1'b0; ready = 1'b1;
    step();
    chk_all("hold_pop", 0, 7'h00, 0, 5'd0, 0, 0);
    ready = 1'b0;

    // Asynchronous reset with three entries queued.
    capture(7'h41); capture(7'h42); capture(7'h43);
    chk("pre_reset.count", {27'd0, count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 7'h00, 0, 5'd0, 0, 0);
    bus = 7'h66; sample = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("post_reset1", 0, 7'h00, 0, 5'd0, 0, 0);
    step();
    chk_all("post_reset2", 0, 7'h00, 0, 5'd0, 0, 0);
    sample = 1'b0;
    step();
    sample = 1'b1;
    step();
    chk_all("post_reset_cap", 1, 7'h66, 0, 5'd1, 0, 0);
    sample = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
